pe_operand_collector: RTL
=========================

PE_OPERAND_COLLECTOR -- requirements
Module: pe_operand_collector

Interface
REQ-001 SHALL have parameter DW, default 32, operand and result width.
REQ-002 SHALL have parameter OPW, default 4, fu opcode width.
REQ-003 SHALL have parameter CW, default 16, iteration counter width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 start  in  1  one-cycle pulse; latches config, begins a run.
REQ-007 cfg_opcode  in  OPW  operation for the run (0 ADD, 1 SUB, 2 MULT, 3 SLL, 4 SRL, 5 AND, 6 OR, 7 NOT, 8 XOR).
REQ-008 cfg_b_imm  in  1  1 means operand b comes from cfg_imm, not port b.
REQ-009 cfg_imm  in  DW  immediate b operand.
REQ-010 cfg_iter  in  CW  number of results to produce in the run.
REQ-011 in_a_valid / in_a_data / in_a_ready  in / in DW / out  operand a stream.
REQ-012 in_b_valid / in_b_data / in_b_ready  in / in DW / out  operand b stream.
REQ-013 fu_a, fu_b  out  DW  operands to the downstream combinational fu.
REQ-014 fu_opcode  out  OPW  latched opcode to the fu.
REQ-015 fu_result  in  DW  combinational fu result.
REQ-016 out_valid / out_data / out_ready  out / out DW / in  result stream.
REQ-017 busy  out  1  high in RUN and DRAIN.
REQ-018 done  out  1  one-cycle pulse at end of run.

Function
REQ-019 FSM states: IDLE, RUN, DRAIN, DONE.
REQ-020 IDLE: start with cfg_iter!=0 -> RUN; start with cfg_iter==0 -> DONE; start latches cfg_opcode, cfg_b_imm, cfg_imm, cfg_iter and clears the fire counter.
REQ-021 start outside IDLE is ignored; config registers are not changed.
REQ-022 Operand buffers: one entry each (a_full, b_full); a buffer loads when its valid and ready are both high.
REQ-023 in_a_ready = (state==RUN) & (!a_full | fire); in_b_ready likewise with b_full and is 0 whenever the latched b_imm=1.
REQ-024 NOT needs operand a only; b_full is not required for NOT, and in_b_ready is 0 when the latched opcode is NOT.
REQ-025 b_need = !b_imm & (opcode!=NOT); operand_rdy = a_full & (b_full | !b_need).
REQ-026 fire = (state==RUN) & operand_rdy & (!out_valid | out_ready).
REQ-027 fu_a = a buffer; fu_b = latched imm when b_imm, else b buffer; fu_opcode = latched opcode.
REQ-028 On fire: out_data <= fu_result; out_valid <= 1; consumed buffers clear unless reloaded the same cycle.
REQ-029 out_valid clears on out_ready & out_valid when there is no fire that cycle.
REQ-030 Latency: operand handshake at edge N, fire in cycle N+1, out_valid high from cycle N+2; sustained throughput is one result per cycle.
REQ-031 Fire counter increments on fire; the fire that makes count == cfg_iter moves RUN -> DRAIN.
REQ-032 DRAIN: all input ready outputs are 0; when out_valid==0, or at the out_ready handshake of the last result, the next state is DONE.
REQ-033 DONE lasts one cycle with done=1, then IDLE; operand buffers are cleared on DONE.
REQ-034 Arithmetic is performed in the fu; out_data is fu_result truncated to DW, and overflow is not flagged.
REQ-035 Unused opcodes (9 to 15) fire normally; out_data is whatever the fu presents.
REQ-036 out_data holds its value while out_valid & !out_ready.
REQ-037 The counter compares at CW bits; cfg_iter = 2^CW-1 completes without wrap.

Reset
REQ-038 rst_n low asynchronously forces IDLE and clears a_full, b_full, out_valid, busy, done, and the counter; out_data, fu_opcode and config registers become 0.
REQ-039 A reset mid-run discards buffered operands and a pending result; no done pulse follows.

Verification
REQ-040 ADD, iter=3, a={1,2,3}, b={10,20,30}, out_ready=1 -> out_data 11, 22, 33 back-to-back; done pulses one cycle after the last handshake.
REQ-041 SUB, b_imm=1, imm=5, iter=2, a={7,5} -> 2, 0; in_b_ready stays 0 throughout.
REQ-042 MULT, iter=2, out_ready=0 for 5 cycles -> first result 0x0000_0006 (a=2, b=3) held stable, second operand pair buffered, in_a_ready=0 until drain; all results delivered in order.
REQ-043 NOT, iter=1, a=0x0000_FFFF, in_b_valid=1 -> out 0xFFFF_0000; b is never accepted.
REQ-044 start with cfg_iter=0 -> done the next cycle, no out_valid; start during RUN is ignored.
REQ-045 rst_n low while out_valid=1 in RUN -> IDLE, out_valid=0, busy=0, no done pulse.

Source files
------------

// File: rtl/pe_operand_collector.sv
// Operand collector for a processing element: buffers one a/b operand each, issues
// them to an external combinational FU, and streams the results for a configured run length.
module pe_operand_collector #(
  parameter int unsigned DW  = 32,
  parameter int unsigned OPW = 4,
  parameter int unsigned CW  = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [OPW-1:0] cfg_opcode,
  input  logic           cfg_b_imm,
  input  logic [DW-1:0]  cfg_imm,
  input  logic [CW-1:0]  cfg_iter,
  input  logic           in_a_valid,
  input  logic [DW-1:0]  in_a_data,
  output logic           in_a_ready,
  input  logic           in_b_valid,
  input  logic [DW-1:0]  in_b_data,
  output logic           in_b_ready,
  output logic [DW-1:0]  fu_a,
  output logic [DW-1:0]  fu_b,
  output logic [OPW-1:0] fu_opcode,
  input  logic [DW-1:0]  fu_result,
  output logic           out_valid,
  output logic [DW-1:0]  out_data,
  input  logic           out_ready,
  output logic           busy,
  output logic           done
);

  localparam logic [OPW-1:0] OP_NOT = OPW'(7);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t         state;
  state_t         state_next;

  logic [OPW-1:0] opcode_q;
  logic           b_imm_q;
  logic [DW-1:0]  imm_q;
  logic [CW-1:0]  iter_q;
  logic [CW-1:0]  cnt_q;
  logic [CW-1:0]  cnt_inc;
  logic           a_full;
  logic           b_full;
  logic [DW-1:0]  a_buf;
  logic [DW-1:0]  b_buf;

  logic           b_need;
  logic           operand_rdy;
  logic           fire;
  logic           last_fire;
  logic           a_load;
  logic           b_load;
  logic           start_ok;

  // Handshake and issue decisions; ready may rise on the cycle a buffer is consumed.
  always_comb begin
    b_need      = !b_imm_q && (opcode_q != OP_NOT);
    operand_rdy = a_full && (b_full || !b_need);
    fire        = (state == S_RUN) && operand_rdy && (!out_valid || out_ready);
    in_a_ready  = (state == S_RUN) && (!a_full || fire);
    in_b_ready  = (state == S_RUN) && b_need && (!b_full || fire);
    a_load      = in_a_valid && in_a_ready;
    b_load      = in_b_valid && in_b_ready;
    cnt_inc     = CW'(cnt_q + CW'(1));
    last_fire   = fire && (cnt_inc == iter_q);
    start_ok    = start && (state == S_IDLE);
  end

  assign fu_a      = a_buf;
  assign fu_b      = b_imm_q ? imm_q : b_buf;
  assign fu_opcode = opcode_q;

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) state_next = (cfg_iter == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        if (last_fire) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        if (!out_valid || out_ready) state_next = S_DONE;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next == S_RUN) || (state_next == S_DRAIN);
      done  <= (state_next == S_DONE);
    end
  end

  // Run configuration and fire counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q <= '0;
      b_imm_q  <= 1'b0;
      imm_q    <= '0;
      iter_q   <= '0;
      cnt_q    <= '0;
    end else if (start_ok) begin
      opcode_q <= cfg_opcode;
      b_imm_q  <= cfg_b_imm;
      imm_q    <= cfg_imm;
      iter_q   <= cfg_iter;
      cnt_q    <= '0;
    end else if (fire) begin
      cnt_q    <= cnt_inc;
    end
  end

  // Single-entry operand buffers; a reload in the firing cycle keeps the entry full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_full <= 1'b0;
      b_full <= 1'b0;
      a_buf  <= '0;
      b_buf  <= '0;
    end else begin
      if (state == S_DONE)  a_full <= 1'b0;
      else if (a_load)      a_full <= 1'b1;
      else if (fire)        a_full <= 1'b0;

      if (state == S_DONE)          b_full <= 1'b0;
      else if (b_load)              b_full <= 1'b1;
      else if (fire && b_need)      b_full <= 1'b0;

      if (a_load) a_buf <= in_a_data;
      if (b_load) b_buf <= in_b_data;
    end
  end

  // Result register holds until accepted downstream
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (fire) begin
      out_valid <= 1'b1;
      out_data  <= fu_result;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
